cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- CPU-side initiator that drives the 4-way set-associative cache array's read/write/address/replace_way interface and services misses from main memory.
- Write-through, write-allocate policy; one outstanding request.
- Owns the per-set round-robin replacement state that selects the victim way on every allocation.
- Sits between the CPU request port and the cache array / main-memory ports.

Parameters:
- NUM_SETS, 32, sets in the cache array; index = address[9:5].
- NUM_WAYS, 4, ways per set; replace_way width = 2.
- TIMEOUT_CYCLES, 255, memory-wait watchdog limit; used only with MEM_TIMEOUT_EN; counter is 8 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  CPU request valid.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_req_write  in  1  1 = write, 0 = read.
- cpu_req_addr  in  32  request address.
- cpu_req_wdata  in  32  write data.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_resp_rdata  out  32  read data; 0 for writes and errors.
- cpu_resp_err  out  1  response error (timeout); constant 0 without MEM_TIMEOUT_EN.
- cache_read  out  1  cache read enable.
- cache_write  out  1  cache write enable.
- cache_address  out  32  cache address.
- cache_write_data  out  32  cache write data.
- cache_replace_way  out  2  victim way for allocation.
- cache_read_data  in  32  cache combinational read data.
- cache_hit  in  1  cache combinational hit.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  memory write/read.
- mem_req_addr  out  32  memory address.
- mem_req_wdata  out  32  memory write data.
- mem_resp_valid  in  1  memory response or write acknowledge.
- mem_resp_rdata  in  32  memory read data.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - All outputs 0, except cpu_req_ready=1.
  - All round-robin pointers 0; latched request registers 0.
  - Reset mid-operation abandons the transaction; no response is issued, and any memory response arriving later is ignored in IDLE.
- States: IDLE, LOOKUP, MEM_RD_REQ, MEM_RD_WAIT, FILL, MEM_WR_REQ, MEM_WR_WAIT, RESP.
- IDLE:
  - cpu_req_ready=1 only in IDLE.
  - On cpu_req_valid, latch addr/wdata/write, then go to LOOKUP.
- LOOKUP:
  - cache_address = latched address; cache_read = 1.
  - Read + cache_hit: latch cache_read_data, go to RESP. A read hit responds 2 cycles after acceptance.
  - Read miss: go to MEM_RD_REQ.
  - Write: cache_write = 1, cache_write_data = wdata, cache_replace_way = ptr[index]. The cache updates the matching way or allocates at the victim.
    - If cache_hit = 0, advance ptr[index] (mod 4).
    - Go to MEM_WR_REQ.
- MEM_RD_REQ / MEM_WR_REQ:
  - mem_req_valid held at 1 with stable addr/wdata/write until mem_req_ready = 1.
  - Then go to the matching *_WAIT state.
- MEM_RD_WAIT: on mem_resp_valid, latch mem_resp_rdata, go to FILL.
- FILL:
  - cache_write = 1, cache_write_data = fill data, cache_replace_way = ptr[index].
  - Advance ptr[index]; go to RESP.
- MEM_WR_WAIT: on mem_resp_valid, go to RESP.
- RESP:
  - cpu_resp_valid = 1 for exactly one cycle; rdata = latched data for reads, 0 for writes.
  - Return to IDLE. The next request can be accepted the following cycle.
- Pointer rules:
  - Pointer wraps 3→0.
  - Pointers change only on allocation: write miss or read fill.
  - Pointers of other sets are never affected.
- Outputs are registered or state-decoded; cache_* and mem_* are 0 in states that do not use them.

Optional Feature:
- MEM_TIMEOUT_EN.
  - Defined: an 8-bit counter runs in MEM_*_REQ and MEM_*_WAIT states and clears on each state entry. When it reaches TIMEOUT_CYCLES:
    - abort to RESP with cpu_resp_err = 1 and rdata = 0;
    - no cache fill is performed and the pointer is unchanged;
    - an aborted write may already have updated the cache.
  - Undefined: no counter; the controller waits indefinitely; cpu_resp_err is tied 0.

Test Plan:
- Read miss then hit:
  - Read 0x0000_0420 (memory returns 0xDEADBEEF) → mem read issued, FILL to way 0, resp rdata = 0xDEADBEEF.
  - Same read again → no mem_req, resp 2 cycles after acceptance.
- Write miss then read:
  - Write 0x0000_1040 ← 0x1234_5678 → cache_write with replace_way 0, mem write issued, resp after ack.
  - Read 0x0000_1040 → hit, rdata = 0x1234_5678.
- Round-robin: five read misses to distinct tags in set 3 → replace_way sequence 0,1,2,3,0; set 4 pointer stays 0.
- Backpressure: mem_req_ready held low 10 cycles → mem_req_valid/addr stable throughout, cpu_req_ready = 0, single response after the handshake.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 8): mem_resp_valid never asserted → cpu_resp_valid with err = 1 and rdata = 0; next read to the same address misses again.
- Reset mid-MEM_RD_WAIT: reset_n pulsed low → outputs 0, cpu_req_ready = 1, no response; a late mem_resp_valid is ignored.

Source files
------------

// File: rtl/cache_controller.sv
// Write-through / write-allocate controller for a 4-way set-associative cache with per-set round-robin victims.
// Define MEM_TIMEOUT_EN to enable the memory-wait watchdog that aborts with cpu_resp_err.
module cache_controller #(
  parameter int NUM_SETS       = 32,
  parameter int NUM_WAYS       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_write,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  output logic        cpu_resp_err,
  output logic        cache_read,
  output logic        cache_write,
  output logic [31:0] cache_address,
  output logic [31:0] cache_write_data,
  output logic [1:0]  cache_replace_way,
  input  logic [31:0] cache_read_data,
  input  logic        cache_hit,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD_REQ, MEM_RD_WAIT, FILL, MEM_WR_REQ, MEM_WR_WAIT, RESP
  } state_t;

  state_t      state, state_nxt;
  logic        write_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [1:0]  ptr_q [NUM_SETS];
  logic [4:0]  idx;
  logic        ptr_adv;
  logic        abort;
  logic        err_q;

  assign idx     = addr_q[9:5];
  assign ptr_adv = (state == FILL) || (state == LOOKUP && write_q && !cache_hit);

  function automatic logic [1:0] next_way(input logic [1:0] w);
    return (w == 2'(NUM_WAYS - 1)) ? 2'd0 : w + 2'd1;
  endfunction

  always_comb begin
    state_nxt         = state;
    cpu_req_ready     = 1'b0;
    cpu_resp_valid    = 1'b0;
    cpu_resp_rdata    = 32'h0;
    cache_read        = 1'b0;
    cache_write       = 1'b0;
    cache_address     = 32'h0;
    cache_write_data  = 32'h0;
    cache_replace_way = 2'd0;
    mem_req_valid     = 1'b0;
    mem_req_write     = 1'b0;
    mem_req_addr      = 32'h0;
    mem_req_wdata     = 32'h0;
    unique case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        cache_address = addr_q;
        cache_read    = 1'b1;
        if (write_q) begin
          // The array updates the matching way on a hit, otherwise allocates at the victim.
          cache_write       = 1'b1;
          cache_write_data  = wdata_q;
          cache_replace_way = ptr_q[idx];
          state_nxt         = MEM_WR_REQ;
        end else begin
          state_nxt = cache_hit ? RESP : MEM_RD_REQ;
        end
      end
      MEM_RD_REQ, MEM_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = write_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = write_q ? wdata_q : 32'h0;
        if (mem_req_ready) state_nxt = write_q ? MEM_WR_WAIT : MEM_RD_WAIT;
      end
      MEM_RD_WAIT: if (mem_resp_valid) state_nxt = FILL;
      MEM_WR_WAIT: if (mem_resp_valid) state_nxt = RESP;
      FILL: begin
        cache_address     = addr_q;
        cache_write       = 1'b1;
        cache_write_data  = data_q;
        cache_replace_way = ptr_q[idx];
        state_nxt         = RESP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = (write_q || err_q) ? 32'h0 : data_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = RESP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_req_valid) begin
        write_q <= cpu_req_write;
        addr_q  <= cpu_req_addr;
        wdata_q <= cpu_req_wdata;
        data_q  <= 32'h0;
      end
      if (state == LOOKUP && !write_q && cache_hit) data_q <= cache_read_data;
      if (state == MEM_RD_WAIT && mem_resp_valid)    data_q <= mem_resp_rdata;
      if (ptr_adv) ptr_q[idx] <= next_way(ptr_q[idx]);
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt;
  logic       in_mem;
  logic       stalled;

  assign in_mem  = (state == MEM_RD_REQ) || (state == MEM_RD_WAIT) ||
                   (state == MEM_WR_REQ) || (state == MEM_WR_WAIT);
  // A handshake or response landing on the limit cycle wins over the abort.
  assign stalled = ((state == MEM_RD_REQ) || (state == MEM_WR_REQ)) ? !mem_req_ready : !mem_resp_valid;
  assign abort   = in_mem && stalled && (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (state_nxt != state) tmo_cnt <= 8'd0;
      else if (in_mem)        tmo_cnt <= tmo_cnt + 8'd1;
      if (state == IDLE && cpu_req_valid) err_q <= 1'b0;
      else if (abort)                     err_q <= 1'b1;
    end
  end

  assign cpu_resp_err = (state == RESP) && err_q;
`else
  assign abort        = 1'b0;
  assign err_q        = 1'b0;
  assign cpu_resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache array and memory, plus a set/way/pointer reference model.
module tb_cache_controller;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req_valid = 1'b0, cpu_req_ready, cpu_req_write = 1'b0;
  logic [31:0] cpu_req_addr = 32'h0, cpu_req_wdata = 32'h0;
  logic        cpu_resp_valid, cpu_resp_err;
  logic [31:0] cpu_resp_rdata;
  logic        cache_read, cache_write, cache_hit;
  logic [31:0] cache_address, cache_write_data, cache_read_data;
  logic [1:0]  cache_replace_way;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  cache_controller #(.NUM_SETS(32), .NUM_WAYS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_err(cpu_resp_err),
    .cache_read(cache_read), .cache_write(cache_write), .cache_address(cache_address),
    .cache_write_data(cache_write_data), .cache_replace_way(cache_replace_way),
    .cache_read_data(cache_read_data), .cache_hit(cache_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  // Cache array: one word per line, tag = addr[31:10], set = addr[9:5].
  bit        env_val [32][4];
  bit [21:0] env_tag [32][4];
  bit [31:0] env_dat [32][4];

  always_comb begin
    cache_hit       = 1'b0;
    cache_read_data = 32'h0;
    for (int w = 0; w < 4; w++)
      if (env_val[cache_address[9:5]][w] && env_tag[cache_address[9:5]][w] == cache_address[31:10]) begin
        cache_hit       = 1'b1;
        cache_read_data = env_dat[cache_address[9:5]][w];
      end
  end

  function automatic int env_slot(input logic [31:0] a, input logic [1:0] victim);
    for (int w = 0; w < 4; w++)
      if (env_val[a[9:5]][w] && env_tag[a[9:5]][w] == a[31:10]) return w;
    return int'(victim);
  endfunction

  always @(posedge clk)
    if (cache_write) begin
      env_val[cache_address[9:5]][env_slot(cache_address, cache_replace_way)] <= 1'b1;
      env_tag[cache_address[9:5]][env_slot(cache_address, cache_replace_way)] <= cache_address[31:10];
      env_dat[cache_address[9:5]][env_slot(cache_address, cache_replace_way)] <= cache_write_data;
    end

  // Main memory contents (bus side) and the reference model's view of memory.
  logic [31:0] mem_arr [logic [26:0]];
  logic [31:0] ref_mem [logic [26:0]];
  bit          ref_v   [32][4];
  bit   [21:0] ref_t   [32][4];
  int          ref_ptr [32];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[31:5], 5'h0} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a[31:5]) ? mem_arr[a[31:5]] : pat(a);
  endfunction

  task automatic ref_expect(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            output bit hit, output logic [1:0] way, output logic [31:0] rd);
    int s, f;
    s = int'(a[9:5]);
    f = -1;
    for (int w = 0; w < 4; w++) if (ref_v[s][w] && ref_t[s][w] == a[31:10]) f = w;
    hit = (f >= 0);
    way = 2'(ref_ptr[s]);
    if (f < 0) begin
      ref_v[s][ref_ptr[s]] = 1'b1;
      ref_t[s][ref_ptr[s]] = a[31:10];
      ref_ptr[s] = (ref_ptr[s] + 1) % 4;
    end
    if (wr) begin
      ref_mem[a[31:5]] = wd;
      rd = 32'h0;
    end else begin
      rd = ref_mem.exists(a[31:5]) ? ref_mem[a[31:5]] : pat(a);
    end
  endtask

  // Observations from the most recent transaction.
  int          o_nreq, o_nwr, o_nresp, o_lat, o_unstable, o_ready_bad, o_reqcyc;
  logic        o_mwr, o_err;
  logic [31:0] o_maddr, o_mwdata, o_rdata;
  logic [1:0]  o_way;

  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int stall, input bit mute);
    int acc, delay, done_at, left;
    bit pend, snap;
    logic [31:0] s_addr, s_wdata, h_addr, h_wdata;
    logic s_wr, h_wr;
    o_nreq = 0; o_nwr = 0; o_nresp = 0; o_lat = -1; o_unstable = 0; o_ready_bad = 0; o_reqcyc = 0;
    o_mwr = 1'b0; o_err = 1'b0; o_maddr = 32'h0; o_mwdata = 32'h0; o_rdata = 32'h0; o_way = 2'd0;
    acc = -1; delay = 0; done_at = 0; left = stall; pend = 0; snap = 0;
    s_addr = 0; s_wdata = 0; s_wr = 0; h_addr = 0; h_wdata = 0; h_wr = 0;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = a; cpu_req_wdata = wd;
    for (int c = 0; c < 600; c++) begin
      if (acc >= 0) cpu_req_valid = 1'b0;
      if (acc < 0 && cpu_req_valid && cpu_req_ready) acc = c;
      else if (acc >= 0 && o_nresp == 0 && cpu_req_ready) o_ready_bad++;
      mem_resp_valid = 1'b0;
      if (pend) begin
        if (delay == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = h_wr ? 32'h0 : mem_rd(h_addr);
          if (h_wr) mem_arr[h_addr[31:5]] = h_wdata;
          pend = 0;
        end else delay--;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        o_reqcyc++;
        if (snap && {s_wr, s_addr, s_wdata} !== {mem_req_write, mem_req_addr, mem_req_wdata}) o_unstable++;
        snap = 1; s_wr = mem_req_write; s_addr = mem_req_addr; s_wdata = mem_req_wdata;
        if (left > 0) left--;
        else begin
          mem_req_ready = 1'b1;
          o_nreq++; o_mwr = mem_req_write; o_maddr = mem_req_addr; o_mwdata = mem_req_wdata;
          h_wr = mem_req_write; h_addr = mem_req_addr; h_wdata = mem_req_wdata;
          pend = !mute; delay = 1; snap = 0;
        end
      end
      if (cache_write) begin o_nwr++; o_way = cache_replace_way; end
      if (cpu_resp_valid) begin
        o_nresp++;
        if (o_nresp == 1) begin o_rdata = cpu_resp_rdata; o_err = cpu_resp_err; o_lat = c - acc; done_at = c; end
      end
      if (o_nresp > 0 && c >= done_at + 2) break;
      @(negedge clk);
    end
    cpu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 32; s++) ref_ptr[s] = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_req_ready, cpu_resp_valid, cpu_resp_err, cache_read, cache_write, mem_req_valid, mem_req_write} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 1000000", {cpu_req_ready, cpu_resp_valid, cpu_resp_err, cache_read, cache_write, mem_req_valid, mem_req_write});
    end
    n_checks++;
    if ({cache_address, cache_write_data, mem_req_addr, mem_req_wdata, cpu_resp_rdata, cache_replace_way} !== 162'h0) begin
      n_fail++; $display("FAIL reset_data got nonzero addr=%h wdata=%h maddr=%h rdata=%h", cache_address, cache_write_data, mem_req_addr, cpu_resp_rdata);
    end
    do_reset();
  endtask

  task automatic test_read_miss_hit();
    bit h; logic [1:0] w; logic [31:0] rd;
    mem_arr[27'(32'h0420 >> 5)] = 32'hDEADBEEF;
    ref_mem[27'(32'h0420 >> 5)] = 32'hDEADBEEF;
    ref_expect(1'b0, 32'h0000_0420, 32'h0, h, w, rd);
    run_txn(1'b0, 32'h0000_0420, 32'h0, 0, 0);
    n_checks++;
    if ({o_nreq, o_mwr, o_maddr} !== {32'd1, 1'b0, 32'h0000_0420}) begin
      n_fail++; $display("FAIL rd_miss_memreq got n=%0d wr=%b addr=%h want 1/0/00000420", o_nreq, o_mwr, o_maddr);
    end
    n_checks++;
    if ({o_nwr, o_way} !== {32'd1, 2'd0}) begin n_fail++; $display("FAIL rd_miss_fill got n=%0d way=%0d want 1/0", o_nwr, o_way); end
    n_checks++;
    if ({o_nresp, o_err, o_rdata} !== {32'd1, 1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL rd_miss_resp got n=%0d err=%b rdata=%h want 1/0/deadbeef", o_nresp, o_err, o_rdata);
    end
    ref_expect(1'b0, 32'h0000_0420, 32'h0, h, w, rd);
    run_txn(1'b0, 32'h0000_0420, 32'h0, 0, 0);
    n_checks++;
    if ({o_nreq, o_nwr, o_lat} !== {32'd0, 32'd0, 32'd2}) begin
      n_fail++; $display("FAIL rd_hit_timing got nreq=%0d nwr=%0d lat=%0d want 0/0/2", o_nreq, o_nwr, o_lat);
    end
    n_checks++;
    if (o_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hit_data got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_write_miss_read();
    bit h; logic [1:0] w; logic [31:0] rd;
    ref_expect(1'b1, 32'h0000_1040, 32'h1234_5678, h, w, rd);
    run_txn(1'b1, 32'h0000_1040, 32'h1234_5678, 0, 0);
    n_checks++;
    if ({o_nwr, o_way} !== {32'd1, 2'd0}) begin n_fail++; $display("FAIL wr_miss_way got n=%0d way=%0d want 1/0", o_nwr, o_way); end
    n_checks++;
    if ({o_nreq, o_mwr, o_maddr, o_mwdata} !== {32'd1, 1'b1, 32'h0000_1040, 32'h1234_5678}) begin
      n_fail++; $display("FAIL wr_miss_mem got n=%0d wr=%b addr=%h data=%h", o_nreq, o_mwr, o_maddr, o_mwdata);
    end
    n_checks++;
    if ({o_nresp, o_rdata} !== {32'd1, 32'h0}) begin n_fail++; $display("FAIL wr_resp got n=%0d rdata=%h want 1/0", o_nresp, o_rdata); end
    ref_expect(1'b0, 32'h0000_1040, 32'h0, h, w, rd);
    run_txn(1'b0, 32'h0000_1040, 32'h0, 0, 0);
    n_checks++;
    if ({o_nreq, o_rdata} !== {32'd0, 32'h1234_5678}) begin
      n_fail++; $display("FAIL wr_then_rd got nreq=%0d rdata=%h want 0/12345678", o_nreq, o_rdata);
    end
  endtask

  task automatic test_round_robin();
    bit h; logic [1:0] w; logic [31:0] rd, a;
    for (int i = 0; i < 5; i++) begin
      a = {22'(32'h100 + i), 5'd3, 5'd0};
      ref_expect(1'b0, a, 32'h0, h, w, rd);
      run_txn(1'b0, a, 32'h0, 0, 0);
      n_checks++;
      if ({o_nwr, o_way, o_rdata} !== {32'd1, 2'(i % 4), rd}) begin
        n_fail++; $display("FAIL rr_set3_%0d got n=%0d way=%0d rdata=%h want way=%0d rdata=%h", i, o_nwr, o_way, o_rdata, i % 4, rd);
      end
    end
    a = {22'h155, 5'd4, 5'd0};
    ref_expect(1'b0, a, 32'h0, h, w, rd);
    run_txn(1'b0, a, 32'h0, 0, 0);
    n_checks++;
    if ({o_nwr, o_way} !== {32'd1, 2'd0}) begin n_fail++; $display("FAIL rr_set4 got n=%0d way=%0d want 1/0", o_nwr, o_way); end
  endtask

  task automatic test_backpressure();
    bit h; logic [1:0] w; logic [31:0] rd, a;
    a = {22'h2AB, 5'd9, 5'd0};
    ref_expect(1'b0, a, 32'h0, h, w, rd);
    run_txn(1'b0, a, 32'h0, 10, 0);
    n_checks++;
    if ({o_unstable, o_ready_bad, o_reqcyc} !== {32'd0, 32'd0, 32'd11}) begin
      n_fail++; $display("FAIL bp_hold got unstable=%0d ready_bad=%0d reqcyc=%0d want 0/0/11", o_unstable, o_ready_bad, o_reqcyc);
    end
    n_checks++;
    if ({o_nreq, o_nresp, o_rdata} !== {32'd1, 32'd1, rd}) begin
      n_fail++; $display("FAIL bp_resp got nreq=%0d nresp=%0d rdata=%h want 1/1/%h", o_nreq, o_nresp, o_rdata, rd);
    end
  endtask

  task automatic test_random();
    bit h; logic [1:0] w; logic [31:0] rd, a, wd;
    logic wr;
    int exp_mem;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = {22'(32'h40 + $urandom_range(0, 5)), 5'(5 + $urandom_range(0, 1)), 5'd0};
      wd = $urandom;
      ref_expect(wr, a, wd, h, w, rd);
      exp_mem = (wr || !h) ? 1 : 0;
      run_txn(wr, a, wd, $urandom_range(0, 3), 0);
      n_checks++;
      if ({o_nresp, o_err, o_rdata} !== {32'd1, 1'b0, rd}) begin
        n_fail++; $display("FAIL rnd%0d_resp got n=%0d err=%b rdata=%h want 1/0/%h", i, o_nresp, o_err, o_rdata, rd);
      end
      n_checks++;
      if ({o_nreq, o_nwr, o_way} !== {exp_mem, exp_mem, exp_mem != 0 ? w : 2'd0}) begin
        n_fail++; $display("FAIL rnd%0d_ctl got nreq=%0d nwr=%0d way=%0d want %0d/%0d/%0d", i, o_nreq, o_nwr, o_way, exp_mem, exp_mem, w);
      end
      if (exp_mem != 0) begin
        n_checks++;
        if ({o_mwr, o_maddr, o_mwdata} !== {wr, a, wr ? wd : 32'h0}) begin
          n_fail++; $display("FAIL rnd%0d_mem got wr=%b addr=%h data=%h want %b/%h", i, o_mwr, o_maddr, o_mwdata, wr, a);
        end
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    bit h; logic [1:0] w; logic [31:0] rd, a;
    a = {22'h3C1, 5'd8, 5'd0};
    run_txn(1'b0, a, 32'h0, 0, 1);
    n_checks++;
    if ({o_nresp, o_err, o_rdata, o_nwr} !== {32'd1, 1'b1, 32'h0, 32'd0}) begin
      n_fail++; $display("FAIL tmo_abort got n=%0d err=%b rdata=%h nwr=%0d want 1/1/0/0", o_nresp, o_err, o_rdata, o_nwr);
    end
    ref_expect(1'b0, a, 32'h0, h, w, rd);
    run_txn(1'b0, a, 32'h0, 0, 0);
    n_checks++;
    if ({o_nreq, o_err, o_way, o_rdata} !== {32'd1, 1'b0, 2'd0, rd}) begin
      n_fail++; $display("FAIL tmo_retry got nreq=%0d err=%b way=%0d rdata=%h want 1/0/0/%h", o_nreq, o_err, o_way, o_rdata, rd);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit h, bad; logic [1:0] w; logic [31:0] rd, a;
    int c;
    a = {22'h377, 5'd7, 5'd0};
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = a;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    c = 0;
    while (!mem_req_valid && c < 20) begin @(negedge clk); c++; end
    n_checks++;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got %b want 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_req_ready, cpu_resp_valid, cache_write, cache_read, mem_req_valid, mem_req_addr} !== {5'b10000, 32'h0}) begin
      n_fail++; $display("FAIL rstmid_out got ready=%b resp=%b cw=%b mreq=%b", cpu_req_ready, cpu_resp_valid, cache_write, mem_req_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 32; s++) ref_ptr[s] = 0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFEED_F00D;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_resp_valid || cache_write || mem_req_valid || !cpu_req_ready) bad = 1;
      @(negedge clk);
      mem_resp_valid = 1'b0;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_resp got activity=%b want 0", bad); end
    ref_expect(1'b0, a, 32'h0, h, w, rd);
    run_txn(1'b0, a, 32'h0, 0, 0);
    n_checks++;
    if ({o_nreq, o_way, o_rdata} !== {32'd1, 2'd0, rd}) begin
      n_fail++; $display("FAIL rstmid_retry got nreq=%0d way=%0d rdata=%h want 1/0/%h", o_nreq, o_way, o_rdata, rd);
    end
  endtask

  initial begin
    for (int s = 0; s < 32; s++) ref_ptr[s] = 0;
    test_reset();
    test_read_miss_hit();
    test_write_miss_read();
    test_round_robin();
    test_backpressure();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end
endmodule
